// File: rtl/half_adder_checker.sv
// Exhaustive self-test sequencer for an external half adder: drives all four
// operand pairs ITER times, waits SETTLE cycles per vector, and tallies mismatches.
module half_adder_checker #(
  parameter int SETTLE = 1,
  parameter int ITER   = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_sum,
  input  logic             dut_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       vec_idx
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [PW-1:0]    PASS_LAST   = PW'(ITER - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  logic [1:0]       state;
  logic [SW-1:0]    settle_cnt;
  logic [PW-1:0]    pass_cnt;
  logic             miss;
  logic             last_vec;
  logic [1:0]       next_idx;
  logic [ERR_W-1:0] err_next;

  // The driven operands are registered, so compare against them directly.
  always_comb begin
    miss     = (dut_sum != (dut_a ^ dut_b)) || (dut_carry != (dut_a & dut_b));
    last_vec = (vec_idx == 2'd3) && (pass_cnt == PASS_LAST);
    next_idx = vec_idx + 2'd1;
    err_next = err_count;
    if (miss && (err_count != ERR_MAX)) begin
      err_next = err_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
      pass_cnt   <= '0;
      vec_idx    <= 2'd0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      mismatch   <= 1'b0;
      err_count  <= '0;
    end else begin
      done     <= 1'b0;
      mismatch <= 1'b0;
      case (state)
        IDLE: begin
          dut_a <= 1'b0;
          dut_b <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            state      <= WAIT;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            vec_idx    <= 2'd0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
          end
        end
        WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          mismatch  <= miss;
          err_count <= err_next;
          if (last_vec) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
            dut_a <= 1'b0;
            dut_b <= 1'b0;
          end else begin
            state      <= WAIT;
            settle_cnt <= '0;
            vec_idx    <= next_idx;
            dut_a      <= next_idx[1];
            dut_b      <= next_idx[0];
            if (vec_idx == 2'd3) begin
              pass_cnt <= pass_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/half_adder_checker.md
HALF_ADDER_CHECKER -- requirements
Module: half_adder_checker

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, meaning the number of wait cycles between driving a vector and sampling the response; legal range is 1 or more.
REQ-002 The block SHALL have parameter ITER, default 1, meaning the number of full passes over the 4 input vectors; legal range is 1 or more.
REQ-003 The block SHALL have parameter ERR_W, default 8, meaning the width of the error counter.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates SHALL occur on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: run request.
REQ-007 Port dut_a, output, 1 bit: DUT operand a.
REQ-008 Port dut_b, output, 1 bit: DUT operand b.
REQ-009 Port dut_sum, input, 1 bit: DUT sum response.
REQ-010 Port dut_carry, input, 1 bit: DUT carry response.
REQ-011 Port busy, output, 1 bit: a run is in progress.
REQ-012 Port done, output, 1 bit: one-cycle run-complete pulse.
REQ-013 Port pass, output, 1 bit: the last completed run had zero mismatches.
REQ-014 Port mismatch, output, 1 bit: one-cycle pulse after a failed compare.
REQ-015 Port err_count, output, ERR_W bits: mismatch count for the current or last run.
REQ-016 Port vec_idx, output, 2 bits: index of the vector currently driven.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 The FSM SHALL have exactly the states IDLE, WAIT and CHECK.
REQ-019 IDLE + start=1 at an edge: the block SHALL go to WAIT with vec_idx=0, {dut_a,dut_b}=00, busy=1, err_count=0, pass=0 and the pass counter cleared.
REQ-020 IDLE + start=0: the block SHALL hold state, with dut_a=dut_b=0 and busy=0.
REQ-021 The vector SHALL be driven as dut_a=vec_idx[1] and dut_b=vec_idx[0], so vectors run in the order 00, 01, 10, 11.
REQ-022 WAIT SHALL last exactly SETTLE cycles and then go to CHECK.
REQ-023 CHECK SHALL last one cycle; at its closing edge the block SHALL compare dut_sum with (dut_a XOR dut_b) and dut_carry with (dut_a AND dut_b).
REQ-024 On any compare difference, err_count SHALL increment and mismatch SHALL be 1 for the following cycle; otherwise mismatch SHALL be 0.
REQ-025 err_count SHALL saturate at 2^ERR_W-1 and SHALL NOT wrap.
REQ-026 CHECK, not the last vector: the block SHALL increment vec_idx, driving the new vector on the same edge, and go to WAIT.
REQ-027 vec_idx SHALL wrap 3->0 and increment the pass counter.
REQ-028 CHECK, last vector (vec_idx=3 and pass counter=ITER-1): the block SHALL go to IDLE with busy=0 and done=1 for one cycle, set pass=1 if the final err_count is 0 after this compare, and set dut_a=dut_b=0.
REQ-029 The period per vector SHALL be SETTLE+1 cycles, and a run SHALL take 4*ITER*(SETTLE+1) cycles from the accepting edge to the done edge.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 start=1 during the done cycle SHALL be accepted, because the FSM is already in IDLE.
REQ-032 pass and err_count SHALL hold their values until the next accepted start.

Reset
REQ-033 While rst_n=0 the block SHALL asynchronously force IDLE, with dut_a, dut_b, busy, done, pass, mismatch, err_count, vec_idx and the pass counter all at 0.
REQ-034 Reset deassertion SHALL take effect at the next clock edge.
REQ-035 Reset mid-run SHALL abort the run with no done pulse.

Verification
REQ-036 Correct combinational half-adder model, SETTLE=1, ITER=1, start pulsed at edge 0 -> vectors 00, 01, 10, 11 driven in turn, done=1 after edge 8, err_count=0, pass=1, mismatch never asserted.
REQ-037 dut_carry stuck at 0, defaults -> a single mismatch pulse after the CHECK of vec_idx=3, err_count=1, pass=0.
REQ-038 dut_sum inverted, ITER=2, SETTLE=2 -> done after edge 24, err_count=8; with ERR_W=2 the same run SHALL give err_count=3 (saturated).
REQ-039 start held high for the whole run -> exactly one run while busy, with a new run starting on the done cycle, so err_count returns to 0 on the next edge.
REQ-040 rst_n pulled low at vec_idx=2 during WAIT -> all outputs 0 immediately, no done pulse; after release with start=0 the block stays IDLE.
